// File: rtl/signed_vedic_mac_pipe_if.sv
// Handshake and data bundle for the pipelined signed Vedic multiply/accumulate unit.
// The master drives operands and out_ready. The slave is the MAC unit.
interface signed_vedic_mac_pipe_if #(
    parameter int W     = 8,
    parameter int ACC_W = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             in_acc_en;
    logic             in_acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_p;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_acc_en, in_acc_clr, out_ready,
        input  in_ready, out_valid, out_p, out_acc, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_acc_en, in_acc_clr, out_ready,
        output in_ready, out_valid, out_p, out_acc, out_ovf
    );
endinterface

// File: rtl/signed_vedic_mac_pipe.sv
// Three-stage signed multiply/accumulate: sign-magnitude split, registered Vedic quadrant
// sub-products, then recombination with sign restore and a wrapping accumulator with sticky overflow.
module vedic_umul #(
    parameter int N = 2
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);
    generate
        if (N == 1) begin : g_bit
            assign p = {1'b0, a & b};
        end else if (N == 2) begin : g_base
            logic c1;
            assign p[0] = a[0] & b[0];
            assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
            assign c1   = (a[1] & b[0]) & (a[0] & b[1]);
            assign p[2] = (a[1] & b[1]) ^ c1;
            assign p[3] = (a[1] & b[1]) & c1;
        end else begin : g_rec
            // Odd widths are zero-padded to an even split; the padding never reaches the low 2N bits.
            localparam int HN = (N + 1) / 2;
            logic [2*HN-1:0]      ax;
            logic [2*HN-1:0]      bx;
            logic [3:0][2*HN-1:0] q;
            logic [4*HN-1:0]      sum;
            assign ax = (2*HN)'(a);
            assign bx = (2*HN)'(b);
            for (genvar gi = 0; gi < 4; gi++) begin : g_q
                vedic_umul #(.N(HN)) u_q (
                    .a ((gi % 2 == 1) ? ax[2*HN-1:HN] : ax[HN-1:0]),
                    .b ((gi / 2 == 1) ? bx[2*HN-1:HN] : bx[HN-1:0]),
                    .p (q[gi])
                );
            end
            assign sum = (4*HN)'(q[0])
                       + (((4*HN)'(q[1]) + (4*HN)'(q[2])) << HN)
                       + ((4*HN)'(q[3]) << (2*HN));
            assign p = sum[2*N-1:0];
        end
    endgenerate
endmodule

module signed_vedic_mac_pipe #(
    parameter int W     = 8,
    parameter int ACC_W = 24
) (
    input logic clk,
    input logic rst,
    signed_vedic_mac_pipe_if.slave bus
);
    localparam int H = W / 2;

    logic                 en;
    logic                 v1_q, v1_d, sign1_q, sign1_d, acc_en1_q, acc_en1_d, acc_clr1_q, acc_clr1_d;
    logic [W-1:0]         mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic                 v2_q, v2_d, sign2_q, sign2_d, acc_en2_q, acc_en2_d, acc_clr2_q, acc_clr2_d;
    logic [3:0][W-1:0]    pp_q, pp_d, pp_w;
    logic                 out_valid_q, out_valid_d, ovf_q, ovf_d;
    logic [2*W-1:0]       p_q, p_d, mag, p_new;
    logic [ACC_W-1:0]     acc_q, acc_d, p_ext, acc_sum;
    logic                 add_ovf;

    // One enable moves every stage, so bubbles travel with the data.
    assign en = !out_valid_q || bus.out_ready;

    always_comb begin
        v1_d       = v1_q;
        sign1_d    = sign1_q;
        mag_a_d    = mag_a_q;
        mag_b_d    = mag_b_q;
        acc_en1_d  = acc_en1_q;
        acc_clr1_d = acc_clr1_q;
        if (en) begin
            v1_d       = bus.in_valid;
            sign1_d    = bus.in_a[W-1] ^ bus.in_b[W-1];
            mag_a_d    = bus.in_a[W-1] ? ({W{1'b0}} - bus.in_a) : bus.in_a;
            mag_b_d    = bus.in_b[W-1] ? ({W{1'b0}} - bus.in_b) : bus.in_b;
            acc_en1_d  = bus.in_acc_en;
            acc_clr1_d = bus.in_acc_clr;
        end
    end

    // Quadrants: 0=LL, 1=HL, 2=LH, 3=HH (bit 0 picks the high half of a, bit 1 of b).
    for (genvar gi = 0; gi < 4; gi++) begin : g_pp
        vedic_umul #(.N(H)) u_pp (
            .a ((gi % 2 == 1) ? mag_a_q[W-1:H] : mag_a_q[H-1:0]),
            .b ((gi / 2 == 1) ? mag_b_q[W-1:H] : mag_b_q[H-1:0]),
            .p (pp_w[gi])
        );
    end

    always_comb begin
        v2_d       = v2_q;
        sign2_d    = sign2_q;
        acc_en2_d  = acc_en2_q;
        acc_clr2_d = acc_clr2_q;
        pp_d       = pp_q;
        if (en) begin
            v2_d       = v1_q;
            sign2_d    = sign1_q;
            acc_en2_d  = acc_en1_q;
            acc_clr2_d = acc_clr1_q;
            pp_d       = pp_w;
        end
    end

    always_comb begin
        mag     = (2*W)'(pp_q[0])
                + (((2*W)'(pp_q[1]) + (2*W)'(pp_q[2])) << H)
                + ((2*W)'(pp_q[3]) << W);
        p_new   = sign2_q ? ({(2*W){1'b0}} - mag) : mag;
        p_ext   = ACC_W'($signed(p_new));
        acc_sum = acc_q + p_ext;
        add_ovf = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);

        out_valid_d = out_valid_q;
        p_d         = p_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        if (en) begin
            out_valid_d = v2_q;
            if (v2_q) begin
                p_d = p_new;
                if (acc_clr2_q) begin
                    acc_d = p_ext;
                    ovf_d = 1'b0;
                end else if (acc_en2_q) begin
                    acc_d = acc_sum;
                    ovf_d = ovf_q | add_ovf;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            sign1_q     <= 1'b0;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            acc_en1_q   <= 1'b0;
            acc_clr1_q  <= 1'b0;
            v2_q        <= 1'b0;
            sign2_q     <= 1'b0;
            acc_en2_q   <= 1'b0;
            acc_clr2_q  <= 1'b0;
            pp_q        <= '0;
            out_valid_q <= 1'b0;
            p_q         <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            sign1_q     <= sign1_d;
            mag_a_q     <= mag_a_d;
            mag_b_q     <= mag_b_d;
            acc_en1_q   <= acc_en1_d;
            acc_clr1_q  <= acc_clr1_d;
            v2_q        <= v2_d;
            sign2_q     <= sign2_d;
            acc_en2_q   <= acc_en2_d;
            acc_clr2_q  <= acc_clr2_d;
            pp_q        <= pp_d;
            out_valid_q <= out_valid_d;
            p_q         <= p_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = p_q;
    assign bus.out_acc   = acc_q;
    assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_signed_vedic_mac_pipe.sv
// Randomised and exhaustive checks of the signed Vedic MAC pipe against an arithmetic reference model.
// W=8 runs with two accumulator widths fed identical stimulus; W=4 and W=16 cover the parameter range.
module tb_signed_vedic_mac_pipe;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    signed_vedic_mac_pipe_if #(.W(8),  .ACC_W(24)) if8  ();
    signed_vedic_mac_pipe_if #(.W(8),  .ACC_W(16)) if8o ();
    signed_vedic_mac_pipe_if #(.W(4),  .ACC_W(8))  if4  ();
    signed_vedic_mac_pipe_if #(.W(16), .ACC_W(32)) if16 ();

    assign if8o.in_valid   = if8.in_valid;
    assign if8o.in_a       = if8.in_a;
    assign if8o.in_b       = if8.in_b;
    assign if8o.in_acc_en  = if8.in_acc_en;
    assign if8o.in_acc_clr = if8.in_acc_clr;
    assign if8o.out_ready  = if8.out_ready;

    signed_vedic_mac_pipe #(.W(8),  .ACC_W(24)) dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
    signed_vedic_mac_pipe #(.W(8),  .ACC_W(16)) dut8o (.clk(clk), .rst(rst), .bus(if8o.slave));
    signed_vedic_mac_pipe #(.W(4),  .ACC_W(8))  dut4  (.clk(clk), .rst(rst), .bus(if4.slave));
    signed_vedic_mac_pipe #(.W(16), .ACC_W(32)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

    typedef struct {
        int          a;
        int          b;
        logic [15:0] p;
        logic [23:0] acc;
        logic        ovf;
        logic [15:0] acc16;
        logic        ovf16;
        int          t;
    } exp8_t;

    typedef struct {
        int     a;
        int     b;
        longint p;
        int     t;
    } sp_t;

    exp8_t  q8[$];
    longint m_acc24 = 0, m_acc16 = 0;
    bit     m_ovf24 = 0, m_ovf16 = 0;

    function automatic longint wrap_s(longint x, int w);
        longint m, r;
        m = longint'(1) << w;
        r = x % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    function automatic void model_reset();
        q8.delete();
        m_acc24 = 0; m_acc16 = 0; m_ovf24 = 0; m_ovf16 = 0;
    endfunction

    // Reference: true product, then accumulate in unbounded arithmetic and wrap to the register width.
    function automatic void model_push(int a, int b, bit en, bit clr);
        exp8_t  e;
        longint p, s;
        p = longint'(a) * longint'(b);
        if (clr) begin
            m_acc24 = p; m_ovf24 = 0;
            m_acc16 = p; m_ovf16 = 0;
        end else if (en) begin
            s = m_acc24 + p; m_acc24 = wrap_s(s, 24); if (m_acc24 != s) m_ovf24 = 1;
            s = m_acc16 + p; m_acc16 = wrap_s(s, 16); if (m_acc16 != s) m_ovf16 = 1;
        end
        e.a = a; e.b = b; e.p = 16'(p);
        e.acc = 24'(m_acc24); e.ovf = m_ovf24;
        e.acc16 = 16'(m_acc16); e.ovf16 = m_ovf16;
        e.t = cyc;
        q8.push_back(e);
    endfunction

    // Drive one cycle of W=8 stimulus; acceptance follows in_ready = !out_valid | out_ready.
    task automatic drive8(input bit v, input int a, input int b, input bit en, input bit clr,
                          input bit ordy, output bit took);
        bit give;
        if8.in_valid = v; if8.in_a = 8'(a); if8.in_b = 8'(b);
        if8.in_acc_en = en; if8.in_acc_clr = clr; if8.out_ready = ordy;
        #1;
        give = if8.out_valid && ordy;
        took = v && (!if8.out_valid || ordy);
        if (give && q8.size() > 0) void'(q8.pop_front());
        if (took) model_push(a, b, en, clr);
    endtask

    task automatic idle_all();
        if8.in_valid = 0; if8.in_a = 0; if8.in_b = 0; if8.in_acc_en = 0; if8.in_acc_clr = 0; if8.out_ready = 1;
        if4.in_valid = 0; if4.in_a = 0; if4.in_b = 0; if4.in_acc_en = 0; if4.in_acc_clr = 0; if4.out_ready = 1;
        if16.in_valid = 0; if16.in_a = 0; if16.in_b = 0; if16.in_acc_en = 0; if16.in_acc_clr = 0; if16.out_ready = 1;
    endtask

    task automatic test_reset();
        idle_all();
        #2 rst = 1'b1;
        #1;
        n_tests++; if (if8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", if8.out_valid); end
        n_tests++; if (if8.out_p !== 16'h0) begin n_fail++; $display("FAIL reset_p: got %h required 0", if8.out_p); end
        n_tests++; if (if8.out_acc !== 24'h0) begin n_fail++; $display("FAIL reset_acc: got %h required 0", if8.out_acc); end
        n_tests++; if (if8.out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b required 0", if8.out_ovf); end
        n_tests++; if (if4.out_valid !== 1'b0 || if16.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid_w4_w16: got %b/%b required 0/0", if4.out_valid, if16.out_valid);
        end
        model_reset();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (if8.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", if8.in_ready); end
        $display("[TB] reset: checked cleared outputs and in_ready after release");
    endtask

    task automatic test_sweep();
        sp_t q4[$], q16[$];
        sp_t s;
        bit  took;
        int  a8, b8;
        for (int k = 0; k < 65536 + 8; k++) begin
            @(negedge clk);
            if (if8.out_valid) begin
                n_tests++;
                if (q8.size() == 0) begin
                    n_fail++; $display("FAIL sweep8_extra: got out_valid=1 required 0");
                end else begin
                    if (if8.out_p !== q8[0].p) begin
                        n_fail++; $display("FAIL sweep8_p a=%0d b=%0d: got %0d required %0d",
                                           q8[0].a, q8[0].b, $signed(if8.out_p), $signed(q8[0].p));
                    end
                    n_tests++;
                    if (cyc - q8[0].t !== LAT) begin
                        n_fail++; $display("FAIL sweep8_latency a=%0d b=%0d: got %0d required %0d",
                                           q8[0].a, q8[0].b, cyc - q8[0].t, LAT);
                    end
                end
            end
            if (if4.out_valid) begin
                n_tests++;
                if (q4.size() == 0) begin
                    n_fail++; $display("FAIL sweep4_extra: got out_valid=1 required 0");
                end else if (if4.out_p !== 8'(q4[0].p) || cyc - q4[0].t !== LAT) begin
                    n_fail++; $display("FAIL sweep4_p a=%0d b=%0d: got %0d lat %0d required %0d lat %0d",
                                       q4[0].a, q4[0].b, $signed(if4.out_p), cyc - q4[0].t, q4[0].p, LAT);
                end
            end
            if (if16.out_valid) begin
                n_tests++;
                if (q16.size() == 0) begin
                    n_fail++; $display("FAIL sweep16_extra: got out_valid=1 required 0");
                end else if (if16.out_p !== 32'(q16[0].p) || cyc - q16[0].t !== LAT) begin
                    n_fail++; $display("FAIL sweep16_p a=%0d b=%0d: got %0d lat %0d required %0d lat %0d",
                                       q16[0].a, q16[0].b, $signed(if16.out_p), cyc - q16[0].t, q16[0].p, LAT);
                end
            end
            if (if4.out_valid && q4.size() > 0) void'(q4.pop_front());
            if (if16.out_valid && q16.size() > 0) void'(q16.pop_front());

            if4.in_valid = (k < 256);
            s.a = int'(wrap_s(longint'(k >> 4), 4));
            s.b = int'(wrap_s(longint'(k), 4));
            if4.in_a = 4'(s.a); if4.in_b = 4'(s.b);
            s.p = longint'(s.a) * longint'(s.b); s.t = cyc;
            if (k < 256) q4.push_back(s);

            if16.in_valid = (k < 10000);
            if (k == 0)      begin s.a = -32768; s.b = -32768; end
            else if (k == 1) begin s.a = 32767;  s.b = -32768; end
            else begin
                s.a = int'(wrap_s(longint'($urandom_range(65535)), 16));
                s.b = int'(wrap_s(longint'($urandom_range(65535)), 16));
            end
            if16.in_a = 16'(s.a); if16.in_b = 16'(s.b);
            s.p = longint'(s.a) * longint'(s.b); s.t = cyc;
            if (k < 10000) q16.push_back(s);

            a8 = int'(wrap_s(longint'(k >> 8), 8));
            b8 = int'(wrap_s(longint'(k), 8));
            drive8(k < 65536, a8, b8, 1'b0, 1'b0, 1'b1, took);
        end
        n_tests++;
        if (q8.size() != 0 || q4.size() != 0 || q16.size() != 0) begin
            n_fail++; $display("FAIL sweep_missing: got pending %0d/%0d/%0d required 0/0/0", q8.size(), q4.size(), q16.size());
        end
        $display("[TB] sweep: W=8 exhaustive, W=4 exhaustive, W=16 10000 pairs");
    endtask

    task automatic test_accumulate();
        int  a_t[3]   = '{3, -2, 10};
        int  b_t[3]   = '{4, 5, 10};
        int  p_t[3]   = '{12, -10, 100};
        int  acc_t[3] = '{12, 2, 102};
        int  n_out = 0;
        int  kk;
        bit  took;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (if8.out_valid) begin
                n_tests++;
                if (n_out >= 3) begin
                    n_fail++; $display("FAIL accum_extra: got out_valid=1 required 0");
                end else if (int'($signed(if8.out_p)) !== p_t[n_out] || int'($signed(if8.out_acc)) !== acc_t[n_out]
                             || if8.out_ovf !== 1'b0 || int'($signed(if8o.out_acc)) !== acc_t[n_out]) begin
                    n_fail++; $display("FAIL accum_%0d: got p=%0d acc=%0d ovf=%b acc16=%0d required p=%0d acc=%0d ovf=0",
                                       n_out, $signed(if8.out_p), $signed(if8.out_acc), if8.out_ovf,
                                       $signed(if8o.out_acc), p_t[n_out], acc_t[n_out]);
                end
                n_out++;
            end
            kk = (k < 3) ? k : 0;
            drive8(k < 3, a_t[kk], b_t[kk], k > 0, k == 0, 1'b1, took);
        end
        n_tests++; if (n_out != 3) begin n_fail++; $display("FAIL accum_count: got %0d required 3", n_out); end
        $display("[TB] accumulate: clr then two en transactions");
    endtask

    task automatic test_overflow();
        int a_t[4]     = '{-128, -128, 0, 1};
        int b_t[4]     = '{-128, -128, 5, 1};
        bit en_t[4]    = '{0, 1, 1, 0};
        bit clr_t[4]   = '{1, 0, 0, 1};
        int acc16_t[4] = '{16384, -32768, -32768, 1};
        bit ovf16_t[4] = '{0, 1, 1, 0};
        int acc24_t[4] = '{16384, 32768, 32768, 1};
        int n_out = 0;
        int kk;
        bit took;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (if8o.out_valid) begin
                n_tests++;
                if (n_out >= 4) begin
                    n_fail++; $display("FAIL ovf_extra: got out_valid=1 required 0");
                end else if (int'($signed(if8o.out_acc)) !== acc16_t[n_out] || if8o.out_ovf !== ovf16_t[n_out]
                             || int'($signed(if8.out_acc)) !== acc24_t[n_out] || if8.out_ovf !== 1'b0) begin
                    n_fail++; $display("FAIL ovf_%0d: got acc16=%0d ovf16=%b acc24=%0d ovf24=%b required %0d %b %0d 0",
                                       n_out, $signed(if8o.out_acc), if8o.out_ovf, $signed(if8.out_acc), if8.out_ovf,
                                       acc16_t[n_out], ovf16_t[n_out], acc24_t[n_out]);
                end
                n_out++;
            end
            kk = (k < 4) ? k : 0;
            drive8(k < 4, a_t[kk], b_t[kk], en_t[kk], clr_t[kk], 1'b1, took);
        end
        n_tests++; if (n_out != 4) begin n_fail++; $display("FAIL ovf_count: got %0d required 4", n_out); end
        $display("[TB] overflow: 16-bit accumulator wrap and sticky flag");
    endtask

    task automatic test_random_mac();
        bit took;
        for (int k = 0; k < 606; k++) begin
            @(negedge clk);
            if (if8.out_valid) begin
                n_tests++;
                if (q8.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra: got out_valid=1 required 0");
                end else if (if8.out_p !== q8[0].p || if8.out_acc !== q8[0].acc || if8.out_ovf !== q8[0].ovf
                             || if8o.out_acc !== q8[0].acc16 || if8o.out_ovf !== q8[0].ovf16) begin
                    n_fail++; $display("FAIL rand_result a=%0d b=%0d: got p=%0d acc=%0d ovf=%b acc16=%0d ovf16=%b required p=%0d acc=%0d ovf=%b acc16=%0d ovf16=%b",
                                       q8[0].a, q8[0].b, $signed(if8.out_p), $signed(if8.out_acc), if8.out_ovf,
                                       $signed(if8o.out_acc), if8o.out_ovf, $signed(q8[0].p), $signed(q8[0].acc),
                                       q8[0].ovf, $signed(q8[0].acc16), q8[0].ovf16);
                end
            end
            drive8(k < 600 && $urandom_range(3) != 0,
                   int'(wrap_s(longint'($urandom_range(255)), 8)), int'(wrap_s(longint'($urandom_range(255)), 8)),
                   $urandom_range(1) == 1, $urandom_range(7) == 0, k >= 600 || $urandom_range(9) < 7, took);
        end
        n_tests++; if (q8.size() != 0) begin n_fail++; $display("FAIL rand_missing: got %0d pending required 0", q8.size()); end
        $display("[TB] random mac: 600 cycles with bubbles and backpressure");
    endtask

    task automatic test_backpressure();
        int          a_t[6], b_t[6];
        int          idx = 0, n_out = 0;
        bit          took, ordy;
        bit          prev_hold = 0;
        logic [15:0] prev_p;
        logic [23:0] prev_acc;
        for (int i = 0; i < 6; i++) begin
            a_t[i] = int'(wrap_s(longint'($urandom_range(255)), 8));
            b_t[i] = int'(wrap_s(longint'($urandom_range(255)), 8));
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (prev_hold) begin
                n_tests++;
                if (if8.out_valid !== 1'b1 || if8.out_p !== prev_p || if8.out_acc !== prev_acc) begin
                    n_fail++; $display("FAIL bp_hold: got valid=%b p=%0d acc=%0d required 1 %0d %0d",
                                       if8.out_valid, $signed(if8.out_p), $signed(if8.out_acc), $signed(prev_p), $signed(prev_acc));
                end
            end
            if (if8.out_valid) begin
                n_tests++;
                if (q8.size() == 0) begin
                    n_fail++; $display("FAIL bp_extra: got out_valid=1 required 0");
                end else if (if8.out_p !== q8[0].p || if8.out_acc !== q8[0].acc || if8.out_ovf !== q8[0].ovf) begin
                    n_fail++; $display("FAIL bp_order a=%0d b=%0d: got p=%0d acc=%0d required p=%0d acc=%0d",
                                       q8[0].a, q8[0].b, $signed(if8.out_p), $signed(if8.out_acc),
                                       $signed(q8[0].p), $signed(q8[0].acc));
                end
            end
            ordy = !(k >= 3 && k < 7);
            if (if8.out_valid && ordy) n_out++;
            prev_hold = if8.out_valid && !ordy;
            prev_p = if8.out_p;
            prev_acc = if8.out_acc;
            drive8(idx < 6, a_t[idx % 6], b_t[idx % 6], 1'b1, idx == 0, ordy, took);
            if (!ordy && if8.out_valid) begin
                n_tests++;
                if (if8.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b required 0", if8.in_ready); end
            end
            if (took) idx++;
        end
        n_tests++;
        if (n_out != 6 || q8.size() != 0) begin
            n_fail++; $display("FAIL bp_count: got %0d delivered %0d pending required 6 and 0", n_out, q8.size());
        end
        $display("[TB] backpressure: 6 pairs with a 4-cycle stall");
    endtask

    task automatic test_reset_mid();
        int a_t[3] = '{5, 3, 2};
        int b_t[3] = '{7, 3, 2};
        bit took;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive8(1'b1, a_t[k], b_t[k], k > 0, k == 0, 1'b1, took);
        end
        @(negedge clk);
        drive8(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, took);
        n_tests++;
        if (if8.out_valid !== 1'b1 || int'($signed(if8.out_acc)) !== 35) begin
            n_fail++; $display("FAIL rmid_inflight: got valid=%b acc=%0d required 1 35", if8.out_valid, $signed(if8.out_acc));
        end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if (if8.out_valid !== 1'b0 || if8.out_acc !== 24'h0 || if8.out_ovf !== 1'b0 || if8.out_p !== 16'h0) begin
            n_fail++; $display("FAIL rmid_clear: got valid=%b acc=%0d ovf=%b p=%0d required 0 0 0 0",
                               if8.out_valid, $signed(if8.out_acc), if8.out_ovf, $signed(if8.out_p));
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_tests++;
            if (if8.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale: got out_valid=%b at cycle %0d required 0", if8.out_valid, k); end
            drive8(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, took);
        end
        $display("[TB] reset mid-operation: in-flight transactions discarded");
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sweep();
        test_accumulate();
        test_overflow();
        test_random_mac();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
